// File: rtl/ahb_des_arbiter_if.sv
// Bus bundle between two AHB-Lite masters, the arbiter and the shared Triple-DES slave port.
// 'master' is the arbiter's view (it masters the slave side); 'slave' is the surrounding system's view.
interface ahb_des_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [1:0]        M0_HTRANS;
    logic [ADDR_W-1:0] M0_HADDR;
    logic              M0_HWRITE;
    logic [2:0]        M0_HSIZE;
    logic [2:0]        M0_HBURST;
    logic [3:0]        M0_HPROT;
    logic              M0_HMASTLOCK;
    logic [DATA_W-1:0] M0_HWDATA;
    logic              M0_HREADY;
    logic              M0_HRESP;
    logic [DATA_W-1:0] M0_HRDATA;

    logic [1:0]        M1_HTRANS;
    logic [ADDR_W-1:0] M1_HADDR;
    logic              M1_HWRITE;
    logic [2:0]        M1_HSIZE;
    logic [2:0]        M1_HBURST;
    logic [3:0]        M1_HPROT;
    logic              M1_HMASTLOCK;
    logic [DATA_W-1:0] M1_HWDATA;
    logic              M1_HREADY;
    logic              M1_HRESP;
    logic [DATA_W-1:0] M1_HRDATA;

    logic              HSEL;
    logic [1:0]        HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK;
    logic [DATA_W-1:0] HWDATA;
    logic              HMASTER;
    logic              HREADY;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        input  M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK, M0_HWDATA,
        output M0_HREADY, M0_HRESP, M0_HRDATA,
        input  M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK, M1_HWDATA,
        output M1_HREADY, M1_HRESP, M1_HRDATA,
        output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HMASTER,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK, M0_HWDATA,
        input  M0_HREADY, M0_HRESP, M0_HRDATA,
        output M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK, M1_HWDATA,
        input  M1_HREADY, M1_HRESP, M1_HRDATA,
        input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HMASTER,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_des_arbiter.sv
// Two-master AHB-Lite arbiter: one-entry address buffer per master, round-robin with lock, onto one slave.
// Latency: slave address phase one cycle after capture. Backpressure: master HREADY low until its data phase ends.
module ahb_des_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_des_arbiter_if.master  bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } aph_t;

    aph_t       m_aph [2];
    logic [1:0] m_req;
    logic [1:0] m_hmastlock;
    logic [1:0] m_hready;
    logic [1:0] cap;

    aph_t       buf_dat [2];
    logic [1:0] pend_vld;
    logic [1:0] busy;
    logic       own_vld;
    logic       owner;
    logic       lock_vld;
    logic       lock_m;
    logic       hold_vld;
    logic       hold_m;
    logic       last_grant;
    logic       hmaster_q;

    logic       win_vld;
    logic       win;
    logic       issue;
    aph_t       sel_aph;

    logic       unused_htrans;
    assign unused_htrans = bus.M0_HTRANS[0] ^ bus.M1_HTRANS[0];

    assign m_aph[0] = {bus.M0_HADDR, bus.M0_HWRITE, bus.M0_HSIZE, bus.M0_HBURST, bus.M0_HPROT, bus.M0_HMASTLOCK};
    assign m_aph[1] = {bus.M1_HADDR, bus.M1_HWRITE, bus.M1_HSIZE, bus.M1_HBURST, bus.M1_HPROT, bus.M1_HMASTLOCK};
    assign m_req       = {bus.M1_HTRANS[1], bus.M0_HTRANS[1]};
    assign m_hmastlock = {bus.M1_HMASTLOCK, bus.M0_HMASTLOCK};

    // A busy master only sees HREADY while its own transfer is in the slave data phase.
    assign m_hready[0] = ~busy[0] | (own_vld & ~owner & bus.HREADY);
    assign m_hready[1] = ~busy[1] | (own_vld &  owner & bus.HREADY);
    assign cap         = m_hready & m_req;

    // A presented-but-stalled address phase is held so the winner cannot change under HREADY=0.
    always_comb begin
        win_vld = 1'b0;
        win     = last_grant;
        if (hold_vld) begin
            win_vld = 1'b1;
            win     = hold_m;
        end else if (lock_vld) begin
            win_vld = pend_vld[lock_m];
            win     = lock_m;
        end else if (&pend_vld) begin
            win_vld = 1'b1;
            win     = ~last_grant;
        end else if (pend_vld[0]) begin
            win_vld = 1'b1;
            win     = 1'b0;
        end else if (pend_vld[1]) begin
            win_vld = 1'b1;
            win     = 1'b1;
        end
    end

    assign issue   = win_vld & bus.HREADY;
    assign sel_aph = buf_dat[win];

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            buf_dat[0] <= '0;
            buf_dat[1] <= '0;
            pend_vld   <= '0;
            busy       <= '0;
            own_vld    <= 1'b0;
            owner      <= FIRST_GRANT;
            lock_vld   <= 1'b0;
            lock_m     <= FIRST_GRANT;
            hold_vld   <= 1'b0;
            hold_m     <= FIRST_GRANT;
            last_grant <= ~FIRST_GRANT;
            hmaster_q  <= FIRST_GRANT;
        end else begin
            hold_vld <= win_vld & ~bus.HREADY;
            hold_m   <= win;
            if (bus.HREADY) begin
                own_vld <= issue;
            end
            if (own_vld && bus.HREADY) begin
                busy[owner] <= 1'b0;
            end
            if (issue) begin
                pend_vld[win] <= 1'b0;
                owner         <= win;
                last_grant    <= win;
                hmaster_q     <= win;
                lock_vld      <= sel_aph.hmastlock;
                lock_m        <= win;
            end else if (lock_vld && !busy[lock_m] && !m_hmastlock[lock_m]) begin
                lock_vld <= 1'b0;
            end
            // A capture in the completion cycle of the same master re-arms busy.
            for (int i = 0; i < 2; i++) begin
                if (cap[i]) begin
                    buf_dat[i]  <= m_aph[i];
                    pend_vld[i] <= 1'b1;
                    busy[i]     <= 1'b1;
                end
            end
        end
    end

    assign bus.HSEL      = win_vld;
    assign bus.HTRANS    = win_vld ? 2'b10 : 2'b00;
    assign bus.HADDR     = sel_aph.haddr;
    assign bus.HWRITE    = sel_aph.hwrite;
    assign bus.HSIZE     = sel_aph.hsize;
    assign bus.HBURST    = sel_aph.hburst;
    assign bus.HPROT     = sel_aph.hprot;
    assign bus.HMASTLOCK = win_vld & sel_aph.hmastlock;
    assign bus.HMASTER   = win_vld ? win : hmaster_q;
    assign bus.HWDATA    = owner ? bus.M1_HWDATA : bus.M0_HWDATA;

    assign bus.M0_HREADY = m_hready[0];
    assign bus.M1_HREADY = m_hready[1];
    assign bus.M0_HRESP  = own_vld & ~owner & bus.HRESP;
    assign bus.M1_HRESP  = own_vld &  owner & bus.HRESP;
    assign bus.M0_HRDATA = bus.HRDATA;
    assign bus.M1_HRDATA = bus.HRDATA;
endmodule
